// File: rtl/frame_serializer.sv
// Frame serializer: latches a parallel frame on start and shifts it out as
// sync word (MSB first), format header bit and LSB-first data words.
module frame_serializer #(
    parameter int          DATA_WIDTH   = 10,
    parameter int          DATA_DEPTH   = 8,
    parameter logic [7:0]  SYNC_PATTERN = 8'hA5,
    parameter int          DIV_WIDTH    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_in,
    input  logic                                  enc_used,
    input  logic                                  start,
    input  logic [DIV_WIDTH-1:0]                  clk_div,
    output logic                                  ready,
    output logic                                  ser_out,
    output logic                                  ser_en,
    output logic                                  busy,
    output logic                                  done
);

    localparam int BIT_W  = $clog2(DATA_WIDTH);
    localparam int WORD_W = $clog2(DATA_DEPTH);

    // Format 1 carries only the low 6 bits of words 0..3.
    localparam logic [BIT_W-1:0]  F0_LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  F1_LAST_BIT  = BIT_W'(5);
    localparam logic [BIT_W-1:0]  SYNC_LAST    = BIT_W'(7);
    localparam logic [WORD_W-1:0] F0_LAST_WORD = WORD_W'(DATA_DEPTH - 1);
    localparam logic [WORD_W-1:0] F1_LAST_WORD = WORD_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        HDR  = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic [BIT_W-1:0]                      r_bit_cnt;
    logic [BIT_W-1:0]                      w_bit_nxt;
    logic [WORD_W-1:0]                     r_word_cnt;
    logic [WORD_W-1:0]                     w_word_nxt;
    logic [DIV_WIDTH-1:0]                  r_div_cnt;
    logic [DIV_WIDTH-1:0]                  w_div_nxt;
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] r_par;
    logic                                  r_enc;
    logic [DIV_WIDTH-1:0]                  r_div;
    logic                                  r_ser_out;
    logic                                  r_ser_en;
    logic                                  r_ready;
    logic                                  r_busy;
    logic                                  r_done;
    logic                                  w_ser_nxt;
    logic                                  w_en_nxt;
    logic                                  w_ready_nxt;
    logic                                  w_done_nxt;
    logic                                  w_accept;
    logic [BIT_W-1:0]                      w_last_bit;
    logic [WORD_W-1:0]                     w_last_word;
    logic [BIT_W-1:0]                      w_bit_inc;
    logic [WORD_W-1:0]                     w_word_inc;
    logic [2:0]                            w_sync_idx;

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign ser_out = r_ser_out;
    assign ser_en  = r_ser_en;
    assign done    = r_done;

    // Next-state, counter and registered-output computation.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_word_nxt  = r_word_cnt;
        w_div_nxt   = r_div_cnt;
        w_ser_nxt   = r_ser_out;
        w_en_nxt    = r_ser_en;
        w_ready_nxt = r_ready;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        w_last_bit  = r_enc ? F1_LAST_BIT : F0_LAST_BIT;
        w_last_word = r_enc ? F1_LAST_WORD : F0_LAST_WORD;
        w_bit_inc   = r_bit_cnt + BIT_W'(1);
        w_word_inc  = r_word_cnt + WORD_W'(1);
        w_sync_idx  = 3'd6 - r_bit_cnt[2:0];
        case (r_state)
            IDLE: begin
                if (start) begin
                    // Bit 0 goes on the line at the accept edge itself.
                    w_accept    = 1'b1;
                    w_state_nxt = SYNC;
                    w_bit_nxt   = '0;
                    w_word_nxt  = '0;
                    w_div_nxt   = clk_div;
                    w_ser_nxt   = SYNC_PATTERN[7];
                    w_en_nxt    = 1'b1;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_ser_nxt   = 1'b1;
                    w_en_nxt    = 1'b0;
                    w_ready_nxt = 1'b1;
                end
            end
            SYNC, HDR, DATA: begin
                if (r_div_cnt != '0) begin
                    w_div_nxt = r_div_cnt - DIV_WIDTH'(1);
                end else begin
                    w_div_nxt = r_div;
                    if (r_state == SYNC) begin
                        if (r_bit_cnt == SYNC_LAST) begin
                            w_state_nxt = HDR;
                            w_bit_nxt   = '0;
                            w_ser_nxt   = r_enc;
                        end else begin
                            w_bit_nxt = w_bit_inc;
                            w_ser_nxt = SYNC_PATTERN[w_sync_idx];
                        end
                    end else if (r_state == HDR) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                        w_word_nxt  = '0;
                        w_ser_nxt   = r_par[0][0];
                    end else if (r_bit_cnt != w_last_bit) begin
                        w_bit_nxt = w_bit_inc;
                        w_ser_nxt = r_par[r_word_cnt][w_bit_inc];
                    end else if (r_word_cnt != w_last_word) begin
                        w_bit_nxt  = '0;
                        w_word_nxt = w_word_inc;
                        w_ser_nxt  = r_par[w_word_inc][0];
                    end else begin
                        w_state_nxt = IDLE;
                        w_bit_nxt   = '0;
                        w_word_nxt  = '0;
                        w_div_nxt   = '0;
                        w_ser_nxt   = 1'b1;
                        w_en_nxt    = 1'b0;
                        w_ready_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_bit_nxt   = '0;
                w_word_nxt  = '0;
                w_div_nxt   = '0;
                w_ser_nxt   = 1'b1;
                w_en_nxt    = 1'b0;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_div_cnt  <= '0;
            r_ser_out  <= 1'b1;
            r_ser_en   <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_word_cnt <= w_word_nxt;
            r_div_cnt  <= w_div_nxt;
            r_ser_out  <= w_ser_nxt;
            r_ser_en   <= w_en_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= ~w_ready_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Frame contents are frozen at accept so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par <= '0;
            r_enc <= 1'b0;
            r_div <= '0;
        end else if (w_accept) begin
            r_par <= par_in;
            r_enc <= enc_used;
            r_div <= clk_div;
        end
    end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 10, word width; DATA_DEPTH, 8, words per frame; SYNC_PATTERN, 8'hA5, 8-bit sync word; DIV_WIDTH, 16, bit-period divider width.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 par_in  input  [DATA_DEPTH-1:0][DATA_WIDTH-1:0]  scrambled frame from the packet scrambler.
REQ-006 enc_used  input  1  frame format: 0 = 64-bit cluster frame, 1 = 16-bit cluster frame.
REQ-007 start  input  1  request to transmit par_in; accepted only when ready=1.
REQ-008 clk_div  input  DIV_WIDTH  bit period minus one, in clk cycles.
REQ-009 ready  output  1  block idle and able to accept start.
REQ-010 ser_out  output  1  serial line; idles at 1.
REQ-011 ser_en  output  1  high while a frame bit is on ser_out.
REQ-012 busy  output  1  inverse of ready.
REQ-013 done  output  1  one-cycle pulse at end of frame.

Function
REQ-014 States SHALL be IDLE, SYNC, HDR, DATA; all outputs registered.
REQ-015 Accept: start=1 and ready=1 at an edge SHALL latch par_in, enc_used and clk_div, and move IDLE->SYNC; later changes on these inputs SHALL not affect the frame.
REQ-016 start while ready=0 SHALL be ignored, with no queuing.
REQ-017 Each transmitted bit SHALL be held on ser_out for exactly clk_div+1 cycles; clk_div=0 gives one bit per cycle; clk_div=65535 gives 65536 cycles per bit.
REQ-018 SYNC SHALL send SYNC_PATTERN MSB first (8 bits), then move SYNC->HDR.
REQ-019 HDR SHALL send one bit equal to the latched enc_used, then move HDR->DATA.
REQ-020 DATA for format 0 SHALL send words 0..7, each with bits 0..9 LSB first (80 bits).
REQ-021 DATA for format 1 SHALL send words 0..3, each with bits 0..5 LSB first (24 bits); bits 6..9 and words 4..7 SHALL not be sent.
REQ-022 Total frame length SHALL be 89 bits for format 0 and 33 bits for format 1.
REQ-023 If the accept edge is cycle T and D = clk_div, bit k SHALL occupy cycles T+1+k(D+1) through T+(k+1)(D+1), with ser_en=1 and ready=0 for those cycles.
REQ-024 In the cycle after the last bit period the block SHALL assert done=1 for one cycle, return to IDLE, and drive ready=1, ser_en=0 and ser_out=1.
REQ-025 start asserted in the done cycle SHALL be accepted, giving back-to-back frames with no gap cycle beyond the done cycle.
REQ-026 Bit and word counters SHALL be sized for 89 bits without wrap; the divider counter SHALL reload to the latched clk_div at every bit boundary.

Reset
REQ-027 On an edge with rst_n=0 the block SHALL go to IDLE with ready=1, busy=0, ser_out=1, ser_en=0, done=0, and all counters and latched data cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame at the next edge, with no done pulse and no further frame bits.
REQ-029 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-030 Format 0, clk_div=0, par_in words all 10'h3FF, start at T -> ser_out = 1,0,1,0,0,1,0,1 (T+1..T+8), 0 at T+9, 1 for T+10..T+89; done at T+90.
REQ-031 Format 1, clk_div=2, word0=10'h015, others 0 -> header bit 1 held 3 cycles; data bits 1,0,1,0,1,0 then 18 zeros, each held 3 cycles; done at T+1+33*3 = T+100.
REQ-032 start pulsed at T+20 during a frame -> ignored; exactly one done; ready low until the done cycle.
REQ-033 par_in and clk_div changed one cycle after accept -> serial stream identical to the latched values.
REQ-034 rst_n low at T+40 of a format-0 frame -> at T+41 ser_out=1, ser_en=0, ready=1; no done pulse; a new start then produces a complete frame.
REQ-035 start held high continuously with clk_div=0, format 1 -> frames repeat every 34 cycles, with a done pulse each time.
